// File: rtl/audio_brightness_follower_if.sv
// Bundle of the audio sample, video timing and brightness signals for audio_brightness_follower.
// master drives the samples and counters; slave (the follower) returns brightness and the frame strobe.
interface audio_brightness_follower_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                           sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] sample_in;
  logic [10:0]                    h_count_in;
  logic [9:0]                     v_count_in;
  logic [7:0]                     brightness_out;
  logic                           frame_strobe;

  modport master (
    output sample_valid, sample_in, h_count_in, v_count_in,
    input  brightness_out, frame_strobe
  );

  modport slave (
    input  sample_valid, sample_in, h_count_in, v_count_in,
    output brightness_out, frame_strobe
  );
endinterface

// File: rtl/audio_brightness_follower.sv
// Per-frame audio peak follower producing an 8-bit brightness.
// The envelope updates once per frame, at the start of vertical blanking.
// Optional square-law output mapping is enabled by defining BRIGHTNESS_GAMMA_EN.
module audio_brightness_follower #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DECAY_SHIFT  = 4,
  parameter int V_ACTIVE     = 720
) (
  input logic                    clk,
  input logic                    rst,
  audio_brightness_follower_if.slave bus
);

  localparam logic [9:0] V_BOUNDARY = 10'(V_ACTIVE);

  logic [SAMPLE_WIDTH-1:0] neg_sample;
  logic [7:0]              mag8;
  logic                    match;
  logic                    match_q;
  logic                    first_q;
  logic                    boundary;
  logic [7:0]              peak;
  logic [7:0]              peak_next;
  logic [7:0]              env;
  logic [7:0]              env_next;
  logic [7:0]              decay_step;
  logic [7:0]              decayed;
  logic                    env_upd_q;
  logic [7:0]              bright_next;
  logic [7:0]              brightness;
  logic                    strobe;

  // Only the most negative code has a negation that is still negative; it saturates to full scale.
  always_comb begin
    neg_sample = ~bus.sample_in + 1'b1;
    if (!bus.sample_in[SAMPLE_WIDTH-1])
      mag8 = bus.sample_in[SAMPLE_WIDTH-2 -: 8];
    else if (neg_sample[SAMPLE_WIDTH-1])
      mag8 = 8'hFF;
    else
      mag8 = neg_sample[SAMPLE_WIDTH-2 -: 8];
  end

  // first_q masks a match that is already present as reset releases.
  assign match    = (bus.h_count_in == 11'd0) && (bus.v_count_in == V_BOUNDARY);
  assign boundary = match && !match_q && !first_q;

  always_comb begin
    peak_next = peak;
    if (boundary)
      peak_next = bus.sample_valid ? mag8 : 8'd0;
    else if (bus.sample_valid && (mag8 > peak))
      peak_next = mag8;
  end

  // env > peak >= 0 on the decay path, so env >= 1 and the subtraction cannot wrap.
  always_comb begin
    decay_step = env >> DECAY_SHIFT;
    if (decay_step == 8'd0)
      decay_step = 8'd1;
    decayed = env - decay_step;
    if (peak >= env)
      env_next = peak;
    else if (decayed > peak)
      env_next = decayed;
    else
      env_next = peak;
  end

`ifdef BRIGHTNESS_GAMMA_EN
  logic [15:0] env_sq;
  logic [16:0] env_sq_rnd;
  always_comb begin
    env_sq      = env * env;
    env_sq_rnd  = {1'b0, env_sq} + 17'd255;
    bright_next = env_sq_rnd[15:8];
  end
`else
  assign bright_next = env;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q    <= 1'b0;
      first_q    <= 1'b1;
      peak       <= 8'd0;
      env        <= 8'd0;
      env_upd_q  <= 1'b0;
      brightness <= 8'd0;
      strobe     <= 1'b0;
    end else begin
      match_q   <= match;
      first_q   <= 1'b0;
      peak      <= peak_next;
      env_upd_q <= boundary;
      strobe    <= env_upd_q;
      if (boundary)
        env <= env_next;
      if (env_upd_q)
        brightness <= bright_next;
    end
  end

  assign bus.brightness_out = brightness;
  assign bus.frame_strobe   = strobe;

endmodule

// File: tb/tb_audio_brightness_follower.sv
// Scoreboard bench for audio_brightness_follower: boundary stimulus queues the expected
// brightness and strobe cycle; a negedge monitor pops and compares on every frame_strobe.
module tb_audio_brightness_follower;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_brightness_follower_if #(.SAMPLE_WIDTH(16)) bus ();

  audio_brightness_follower #(
    .SAMPLE_WIDTH(16),
    .DECAY_SHIFT (4),
    .V_ACTIVE    (720)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] val;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] map_env(input logic [7:0] e);
`ifdef BRIGHTNESS_GAMMA_EN
    int p;
    p = int'(e) * int'(e);
    return 8'((p + 255) >> 8);
`else
    return e;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.frame_strobe === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cycle=%0d brightness=%0d, no strobe expected", cyc, bus.brightness_out);
      end else begin
        e = sb.pop_front();
        if (bus.brightness_out !== e.val || cyc != e.at) begin
          failures++;
          $display("FAIL frame_brightness cycle=%0d got=%0d, expected %0d at cycle %0d",
                   cyc, bus.brightness_out, e.val, e.at);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_counters();
    bus.h_count_in = 11'd100;
    bus.v_count_in = 10'd300;
  endtask

  task automatic send_sample(input logic [15:0] s);
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    tick();
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    tick(2);
  endtask

  task automatic boundary(input logic [7:0] env_exp, input bit with_s = 1'b0,
                          input logic [15:0] s = 16'h0000);
    exp_t e;
    bus.h_count_in = 11'd0;
    bus.v_count_in = 10'd720;
    if (with_s) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = s;
    end
    e.val = map_env(env_exp);
    e.at  = cyc + 2;
    sb.push_back(e);
    tick();
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    idle_counters();
    tick(4);
  endtask

  task automatic hold(input logic [9:0] v, input int n, input logic [7:0] env_exp);
    exp_t e;
    bus.h_count_in = 11'd0;
    bus.v_count_in = v;
    if (v == 10'd720) begin
      e.val = map_env(env_exp);
      e.at  = cyc + 2;
      sb.push_back(e);
    end
    tick(n);
    idle_counters();
    tick(4);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.brightness_out !== 8'd0 || bus.frame_strobe !== 1'b0) begin
      failures++;
      $display("FAIL %s brightness=%0d strobe=%0b, expected 0 and 0",
               name, bus.brightness_out, bus.frame_strobe);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.h_count_in   = 11'd0;
    bus.v_count_in   = 10'd720;
    tick(3);
    rst = 1'b0;
    tick(3);
    check_idle("reset_on_boundary");
    idle_counters();
    tick(3);
    check_idle("reset_idle");

    send_sample(16'h4000);
    tick(5);
    boundary(8'd128);
    boundary(8'd120);
    boundary(8'd113);
    boundary(8'd106);

    send_sample(16'h8000);
    boundary(8'd255);
    send_sample(16'h8001);
    boundary(8'd255);

    send_sample(16'h7FFF);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    check_idle("midframe_reset");
    send_sample(16'h0500);
    boundary(8'd10);
    boundary(8'd9);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    send_sample(16'h0080);
    boundary(8'd1);
    boundary(8'd0);
    boundary(8'd0);

    boundary(8'd0, 1'b1, 16'h7FFF);
    boundary(8'd255);

    send_sample(16'hC000);
    boundary(8'd240);

    hold(10'd720, 5, 8'd225);
    hold(10'd719, 5, 8'd0);

    send_sample(16'h6E00);
    boundary(8'd220);

    tick(6);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes pending=%0d, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_brightness_follower.md
# audio_brightness_follower

Converts the dry audio sample stream into a per-frame 8-bit brightness value that drives `brightness_from_dry` of the video combiner stage. It captures the peak magnitude over each video frame and updates an attack/decay envelope once per frame at the start of vertical blanking, so brightness never changes mid-frame. It sits between the audio path and the video pixel pipeline, clocked in the pixel clock domain.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: signed audio sample width; must be ≥ 9.
- `DECAY_SHIFT`, 4: envelope decay step is `env >> DECAY_SHIFT`, with a minimum step of 1.
- `V_ACTIVE`, 720: first vertical-blanking line number.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `sample_valid` in 1: one-cycle strobe qualifying `sample_in`.
- `sample_in` in SAMPLE_WIDTH: signed two's-complement dry sample.
- `h_count_in` in 11: horizontal pixel counter from the video timing generator.
- `v_count_in` in 10: vertical line counter.
- `brightness_out` out 8: registered envelope brightness, to `brightness_from_dry`.
- `frame_strobe` out 1: one-cycle pulse in the same cycle `brightness_out` takes a new value.

## Operation
- **Magnitude:** `mag = |sample_in|`, saturated to `2^(SAMPLE_WIDTH-1)-1`. The most negative value maps to full scale. `mag8 = mag[SAMPLE_WIDTH-2 -: 8]`.
- **Peak capture:** on `sample_valid`, `peak <= max(peak, mag8)`.
- **Boundary match:** `h_count_in == 0 && v_count_in == V_ACTIVE`.
  - The boundary is a rising edge of the match, detected against a registered previous match. A counter held at the match value for several cycles gives exactly one boundary.
- **At boundary cycle T:**
  - Envelope update, using the `peak` value before T:
    - If `peak >= env`: `env <= peak` (instant attack).
    - Else: `env <= max(env - max(env >> DECAY_SHIFT, 1), peak)`.
  - Peak restart: `peak <= (sample_valid ? mag8 : 0)`. A sample arriving in cycle T belongs to the new window.
- **Output stage:** `brightness_out` is loaded from `env`, after the optional gamma step, only in the cycle after `env` updates. Otherwise it holds.
- **Arithmetic:** all envelope arithmetic is unsigned 8-bit. Decay never underflows and `env` never drops below `peak`.

## Timing
- **Reset values:** `env`, `peak`, `brightness_out` = 0; `frame_strobe` = 0; previous-match register = 0.
  - If the counters sit on the boundary when `rst` deasserts, that does not count as an edge.
- **Latency:** boundary match at input cycle T → `env` valid at T+1 → `brightness_out` and `frame_strobe` = 1 at T+2. The strobe is high for exactly one cycle.
- **Latency independence:** latency is identical with and without `BRIGHTNESS_GAMMA_EN`.
- **Mid-operation reset:** a reset asserted mid-frame discards the partial peak. The first boundary after reset produces an output computed from samples since reset only.
- **Sample rate:** no handshake back-pressure. `sample_valid` may assert on any cycle, including back-to-back cycles.

## Configuration
- **`BRIGHTNESS_GAMMA_EN` defined:** `brightness_out <= (env*env + 255) >> 8`, a square law that gives 0→0, 128→64, 255→255. The 16-bit product is computed in the T+1→T+2 stage.
- **Not defined:** `brightness_out <= env`, a linear mapping.

## Test plan
All scenarios use `SAMPLE_WIDTH=16`, `DECAY_SHIFT=4`, gamma disabled unless stated.

1. **Reset:** assert `rst` for 3 cycles with counters running → `brightness_out` = 0 and `frame_strobe` = 0; no strobe until the next boundary edge.
2. **Attack:** one sample `0x4000` mid-frame, then boundary at T → `brightness_out` = 128 with `frame_strobe` = 1 at T+2. With `BRIGHTNESS_GAMMA_EN`, `brightness_out` = 64.
3. **Saturation:** sample `0x8000` (−32768), then boundary → `brightness_out` = 255. Sample `0x8001` gives 255.
4. **Decay:** `env` = 128, then silent frames → `brightness_out` = 120, then 113, then 106. With `env` = 10 → 9. With `env` = 1 → 0, then stays 0 with a strobe every frame.
5. **Sample on boundary:** `env` = 0, silent frame, `sample_valid` with `0x7FFF` in cycle T → output at T+2 is 0. The next boundary gives 255.
6. **Held counters:** counters frozen at (0, 720) for 5 cycles → exactly one `frame_strobe`. Counters frozen at (0, 719) → no strobe.
